// File: rtl/cpu_run_pkg.sv
// Shared types and width helpers for the CPU run controller.
// Holds the run FSM state encoding and the counter sizing function.
package cpu_run_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } run_state_e;

  // Bits needed to hold every value 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cpu_run_controller_stall.sv
// PC stall detector: flags a halt once the same PC has been
// sampled HALT_CYCLES+1 consecutive RUN cycles.
module pc_stall_detector
  import cpu_run_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int HALT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_halt
);

  localparam int SW = cnt_w(HALT_CYCLES);
  localparam logic [SW-1:0] HALT_N = SW'(HALT_CYCLES);

  logic [PC_WIDTH-1:0] r_pc_last;
  logic [SW-1:0]       r_stall_cnt;
  logic                r_first;
  logic                w_match;
  logic [SW-1:0]       w_stall_nxt;

  // The first RUN sample has no predecessor, so it never matches.
  assign w_match = !r_first && (i_pc == r_pc_last);

  always_comb begin
    w_stall_nxt = '0;
    if (w_match) begin
      if (r_stall_cnt == HALT_N) w_stall_nxt = r_stall_cnt;
      else w_stall_nxt = r_stall_cnt + SW'(1);
    end
  end

  assign o_halt = i_en && w_match && (w_stall_nxt == HALT_N);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_pc_last   <= '0;
      r_stall_cnt <= '0;
      r_first     <= 1'b1;
    end else if (i_en) begin
      r_pc_last   <= i_pc;
      r_stall_cnt <= w_stall_nxt;
      r_first     <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller: sequences CPU reset, watches the PC for a halt
// or cycle budget expiry, and holds pass/fail results.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = 3,
  parameter int HALT_CYCLES  = 16,
  parameter int MAX_CYCLES   = 1000000,
  parameter logic [PC_WIDTH-1:0] PASS_PC = PC_WIDTH'(32'h0000_000C),
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset_n,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  cpu_pc,
  output logic                 cpu_reset_n,
  output logic                 busy,
  output logic                 done,
  output logic                 halted,
  output logic                 timeout,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [PC_WIDTH-1:0]  pc_final
);

  localparam int RW = cnt_w(RESET_CYCLES);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;

  run_state_e           r_state;
  logic [RW-1:0]        r_rst_cnt;
  logic                 r_cpu_reset_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_halted;
  logic                 r_timeout;
  logic                 r_pass;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [PC_WIDTH-1:0]  r_pc_final;

  logic w_en;
  logic w_halt;
  logic w_launch;
  logic w_tmo;

  assign w_en     = (r_state == RUN);
  assign w_launch = start || AUTO_RESTART;
  assign w_tmo    = (r_cycle_count == CNT_LAST);

  pc_stall_detector #(
    .PC_WIDTH   (PC_WIDTH),
    .HALT_CYCLES(HALT_CYCLES)
  ) u_stall (
    .clk   (sys_clk),
    .rst_n (sys_reset_n),
    .i_clr (!w_en),
    .i_en  (w_en),
    .i_pc  (cpu_pc),
    .o_halt(w_halt)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      r_state       <= IDLE;
      r_rst_cnt     <= '0;
      r_cpu_reset_n <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_halted      <= 1'b0;
      r_timeout     <= 1'b0;
      r_pass        <= 1'b0;
      r_cycle_count <= '0;
      r_pc_final    <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (w_launch) begin
            r_state       <= RESET;
            r_rst_cnt     <= '0;
            r_cpu_reset_n <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
            r_pass        <= 1'b0;
            r_cycle_count <= '0;
            r_pc_final    <= '0;
          end
        end
        RESET: begin
          if (r_rst_cnt == RST_LAST) begin
            r_state       <= RUN;
            r_cpu_reset_n <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + RW'(1);
          end
        end
        RUN: begin
          if (r_cycle_count != CNT_SAT)
            r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
          // Halt has priority when both end conditions coincide.
          if (w_halt || w_tmo) begin
            r_state       <= DONE;
            r_cpu_reset_n <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_halted      <= w_halt;
            r_timeout     <= !w_halt;
            r_pass        <= w_halt && (cpu_pc == PASS_PC);
            r_pc_final    <= cpu_pc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_reset_n = r_cpu_reset_n;
  assign busy        = r_busy;
  assign done        = r_done;
  assign halted      = r_halted;
  assign timeout     = r_timeout;
  assign pass        = r_pass;
  assign cycle_count = r_cycle_count;
  assign pc_final    = r_pc_final;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller across four parameter builds:
// default, short timeout, coincident halt/timeout, auto-restart.
module tb_cpu_run_controller;

  logic sys_clk;
  logic sys_reset_n;
  logic [31:0] cpu_pc;
  logic start_a, start_t, start_s, start_x;

  logic a_crn, a_busy, a_done, a_halt, a_to, a_pass;
  logic [31:0] a_cc, a_pcf;
  logic t_crn, t_busy, t_done, t_halt, t_to, t_pass;
  logic [31:0] t_cc, t_pcf;
  logic s_crn, s_busy, s_done, s_halt, s_to, s_pass;
  logic [31:0] s_cc, s_pcf;
  logic x_crn, x_busy, x_done, x_halt, x_to, x_pass;
  logic [31:0] x_cc, x_pcf;

  int n_chk  = 0;
  int n_pass = 0;

  cpu_run_controller u_a (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .start(start_a), .cpu_pc(cpu_pc),
    .cpu_reset_n(a_crn), .busy(a_busy), .done(a_done),
    .halted(a_halt), .timeout(a_to), .pass(a_pass),
    .cycle_count(a_cc), .pc_final(a_pcf)
  );

  cpu_run_controller #(.MAX_CYCLES(50)) u_t (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .start(start_t), .cpu_pc(cpu_pc),
    .cpu_reset_n(t_crn), .busy(t_busy), .done(t_done),
    .halted(t_halt), .timeout(t_to), .pass(t_pass),
    .cycle_count(t_cc), .pc_final(t_pcf)
  );

  cpu_run_controller #(.MAX_CYCLES(20), .HALT_CYCLES(4)) u_s (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .start(start_s), .cpu_pc(cpu_pc),
    .cpu_reset_n(s_crn), .busy(s_busy), .done(s_done),
    .halted(s_halt), .timeout(s_to), .pass(s_pass),
    .cycle_count(s_cc), .pc_final(s_pcf)
  );

  cpu_run_controller #(
    .MAX_CYCLES(1000), .HALT_CYCLES(4), .AUTO_RESTART(1'b1)
  ) u_x (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .start(start_x), .cpu_pc(cpu_pc),
    .cpu_reset_n(x_crn), .busy(x_busy), .done(x_done),
    .halted(x_halt), .timeout(x_to), .pass(x_pass),
    .cycle_count(x_cc), .pc_final(x_pcf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  initial begin
    sys_reset_n = 1'b0;
    cpu_pc  = '0;
    start_a = 1'b0;
    start_t = 1'b0;
    start_s = 1'b0;
    start_x = 1'b0;

    // Reset values and start sequencing
    repeat (3) tick();
    chk("rst_crn", a_crn, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_halt", a_halt, 0);
    chk("rst_to", a_to, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_cc", a_cc, 0);
    chk("rst_pcf", a_pcf, 0);
    sys_reset_n = 1'b1;
    repeat (2) tick();
    chk("idle_busy", a_busy, 0);
    chk("idle_crn", a_crn, 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("k_busy", a_busy, 1);
    chk("k_crn", a_crn, 0);
    tick();
    tick();
    chk("k2_crn", a_crn, 0);
    tick();
    chk("k3_crn", a_crn, 1);
    chk("k3_busy", a_busy, 1);
    chk("k3_done", a_done, 0);

    // Halt pass: 0,4,8 then hold 0xC
    for (int i = 0; i < 20; i++) begin
      cpu_pc = (i < 3) ? 32'(i * 4) : 32'hC;
      tick();
      if (i == 18) chk("hp_early", a_done, 0);
    end
    chk("hp_done", a_done, 1);
    chk("hp_halt", a_halt, 1);
    chk("hp_pass", a_pass, 1);
    chk("hp_to", a_to, 0);
    chk("hp_pcf", a_pcf, 32'hC);
    chk("hp_cc", a_cc, 20);
    chk("hp_busy", a_busy, 0);
    chk("hp_crn", a_crn, 0);
    cpu_pc = 32'h99;
    repeat (3) tick();
    chk("hold_done", a_done, 1);
    chk("hold_pcf", a_pcf, 32'hC);

    // Halt fail: PC stuck at 0x40, restart from DONE
    cpu_pc = 32'h40;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("rs_done", a_done, 0);
    chk("rs_halt", a_halt, 0);
    chk("rs_pcf", a_pcf, 0);
    chk("rs_busy", a_busy, 1);
    repeat (3) tick();
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 16) chk("hf_early", a_done, 0);
    end
    chk("hf_done", a_done, 1);
    chk("hf_halt", a_halt, 1);
    chk("hf_pass", a_pass, 0);
    chk("hf_pcf", a_pcf, 32'h40);
    chk("hf_cc", a_cc, 17);

    // start mid-RUN ignored, then abort via sys_reset_n
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      cpu_pc = 32'(i * 4 + 256);
      start_a = (i == 2);
      tick();
    end
    start_a = 1'b0;
    chk("ign_crn", a_crn, 1);
    chk("ign_cc", a_cc, 5);
    chk("ign_busy", a_busy, 1);
    sys_reset_n = 1'b0;
    tick();
    chk("ab_busy", a_busy, 0);
    chk("ab_crn", a_crn, 0);
    chk("ab_cc", a_cc, 0);
    chk("ab_done", a_done, 0);
    chk("ab_pcf", a_pcf, 0);
    sys_reset_n = 1'b1;
    tick();

    // Timeout after 50 RUN cycles
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 50; i++) begin
      cpu_pc = 32'(i * 4);
      tick();
      if (i == 48) chk("to_early", t_done, 0);
    end
    chk("to_done", t_done, 1);
    chk("to_to", t_to, 1);
    chk("to_halt", t_halt, 0);
    chk("to_cc", t_cc, 50);
    chk("to_pcf", t_pcf, 196);
    chk("to_pass", t_pass, 0);

    // Halt and timeout coincide on the 20th RUN edge
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 20; i++) begin
      cpu_pc = (i < 15) ? 32'(i * 4) : 32'd60;
      tick();
      if (i == 18) chk("sim_early", s_done, 0);
    end
    chk("sim_done", s_done, 1);
    chk("sim_halt", s_halt, 1);
    chk("sim_to", s_to, 0);
    chk("sim_cc", s_cc, 20);
    chk("sim_pcf", s_pcf, 60);

    // Auto-restart build
    sys_reset_n = 1'b0;
    cpu_pc = 32'hC;
    tick();
    chk("ar_rst_busy", x_busy, 0);
    sys_reset_n = 1'b1;
    tick();
    chk("ar_busy", x_busy, 1);
    chk("ar_crn", x_crn, 0);
    repeat (3) tick();
    chk("ar_run_crn", x_crn, 1);
    repeat (4) tick();
    chk("ar_early", x_done, 0);
    tick();
    chk("ar_done", x_done, 1);
    chk("ar_halt", x_halt, 1);
    chk("ar_pass", x_pass, 1);
    chk("ar_cc", x_cc, 5);
    tick();
    chk("ar_re_done", x_done, 0);
    chk("ar_re_busy", x_busy, 1);
    chk("ar_re_halt", x_halt, 0);
    chk("ar_re_cc", x_cc, 0);
    chk("ar_re_pcf", x_pcf, 0);
    chk("ar_re_crn", x_crn, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
